// File: rtl/alu_core.sv
// alu_core: unsigned 16-function ALU with a registered result and valid flag.
module alu_core #(
  parameter int A_width = 16,
  parameter int B_width = 16
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       ALU_EN,
  input  logic [A_width-1:0]         A,
  input  logic [B_width-1:0]         B,
  input  logic [3:0]                 ALU_FUN,
  output logic [A_width+B_width-1:0] ALU_out,
  output logic                       Out_valid
);
  localparam int OW = A_width + B_width;
  localparam int MW = (A_width > B_width) ? A_width : B_width;
  logic [OW-1:0] a_x, b_x, mask, res, alu_out_d, alu_out_q;
  logic out_valid_d, out_valid_q;
  always_comb begin
    a_x  = OW'(A);
    b_x  = OW'(B);
    mask = (OW'(1) << MW) - OW'(1);
    res  = '0;
    case (ALU_FUN)
      4'd0:  res = a_x + b_x;
      4'd1:  res = a_x - b_x;
      4'd2:  res = a_x * b_x;
      4'd3:  res = (B == '0) ? '0 : a_x / b_x;
      4'd4:  res = a_x & b_x;
      4'd5:  res = a_x | b_x;
      4'd6:  res = ~(a_x & b_x) & mask;
      4'd7:  res = ~(a_x | b_x) & mask;
      4'd8:  res = a_x ^ b_x;
      4'd9:  res = ~(a_x ^ b_x) & mask;
      4'd10: res = (a_x == b_x) ? OW'(1) : '0;
      4'd11: res = (a_x > b_x) ? OW'(2) : '0;
      4'd12: res = (a_x < b_x) ? OW'(3) : '0;
      4'd13: res = a_x >> 1;
      4'd14: res = a_x << 1;
      default: res = '0;
    endcase
    alu_out_d   = ALU_EN ? res : '0;
    out_valid_d = ALU_EN;
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      alu_out_q   <= alu_out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign ALU_out   = alu_out_q;
  assign Out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed table-driven checks of alu_core plus reset corner cases.
module tb_alu_core;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        ALU_EN = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [3:0]  ALU_FUN = '0;
  logic [31:0] ALU_out;
  logic        Out_valid;
  int          n_run = 0;
  int          n_fail = 0;
  typedef struct {
    string       name;
    logic        en;
    logic [3:0]  fun;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_out;
    logic        exp_v;
  } vec_t;
  vec_t vec[$];
  alu_core #(.A_width(16), .B_width(16)) dut (
    .CLK(CLK), .Reset(Reset), .ALU_EN(ALU_EN), .A(A), .B(B),
    .ALU_FUN(ALU_FUN), .ALU_out(ALU_out), .Out_valid(Out_valid)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string name, input logic [31:0] exp_out, input logic exp_v);
    n_run++;
    if (ALU_out !== exp_out || Out_valid !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got out=%0h valid=%0b, expected out=%0h valid=%0b",
               name, ALU_out, Out_valid, exp_out, exp_v);
    end
  endtask
  task automatic add(input string name, input logic en, input logic [3:0] fun,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp_out, input logic exp_v);
    vec_t v;
    v = '{name, en, fun, a, b, exp_out, exp_v};
    vec.push_back(v);
  endtask
  task automatic drive(input logic en, input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    ALU_EN = en; ALU_FUN = fun; A = a; B = b;
  endtask
  initial begin
    add("add",      1, 0,  16'd11,   16'd300,  32'd311,       1);
    add("add_max",  1, 0,  16'hFFFF, 16'hFFFF, 32'h0001FFFE,  1);
    add("sub",      1, 1,  16'd542,  16'd42,   32'd500,       1);
    add("sub_wrap", 1, 1,  16'd5,    16'd6,    32'hFFFFFFFF,  1);
    add("mul",      1, 2,  16'd2222, 16'd2222, 32'd4937284,   1);
    add("mul_max",  1, 2,  16'hFFFF, 16'hFFFF, 32'hFFFE0001,  1);
    add("div",      1, 3,  16'd999,  16'd9,    32'd111,       1);
    add("div0",     1, 3,  16'd999,  16'd0,    32'd0,         1);
    add("and",      1, 4,  16'hBAAA, 16'h8CEE, 32'h000088AA,  1);
    add("or",       1, 5,  16'hBAAA, 16'h8CEE, 32'h0000BEEE,  1);
    add("nand",     1, 6,  16'hBAAA, 16'h8CEE, 32'h00007755,  1);
    add("nor",      1, 7,  16'hBAAA, 16'h8CEE, 32'h00004111,  1);
    add("xor",      1, 8,  16'hBAAA, 16'h8CEE, 32'h00003644,  1);
    add("xnor",     1, 9,  16'hBAAA, 16'h8CEE, 32'h0000C9BB,  1);
    add("eq_t",     1, 10, 16'd762,  16'd762,  32'd1,         1);
    add("eq_f",     1, 10, 16'd342,  16'd711,  32'd0,         1);
    add("gt_t",     1, 11, 16'd7787, 16'd778,  32'd2,         1);
    add("gt_f",     1, 11, 16'd7628, 16'd7911, 32'd0,         1);
    add("gt_eq",    1, 11, 16'd50,   16'd50,   32'd0,         1);
    add("lt_t",     1, 12, 16'd7877, 16'd7977, 32'd3,         1);
    add("lt_f",     1, 12, 16'd7628, 16'd71,   32'd0,         1);
    add("shr",      1, 13, 16'hD5B5, 16'd0,    32'h00006ADA,  1);
    add("shl",      1, 14, 16'hD5B5, 16'd0,    32'h0001AB6A,  1);
    add("fun15",    1, 15, 16'hD5B5, 16'h1234, 32'd0,         1);
    add("dis",      0, 0,  16'd6,    16'd6,    32'd0,         0);
    add("reen",     1, 0,  16'd6,    16'd6,    32'd12,        1);
    // Async reset with no clock edge must clear immediately.
    #2;
    Reset = 1'b0;
    #1;
    check("rst_async", 32'd0, 1'b0);
    Reset = 1'b1;
    #1;
    check("rst_release", 32'd0, 1'b0);
    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].en, vec[i].fun, vec[i].a, vec[i].b);
      @(posedge CLK);
      #1;
      check(vec[i].name, vec[i].exp_out, vec[i].exp_v);
    end
    drive(1, 0, 16'd100, 16'd200);
    @(posedge CLK);
    #1;
    check("pre_rst", 32'd300, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check("rst_mid", 32'd0, 1'b0);
    @(posedge CLK);
    #1;
    check("rst_hold", 32'd0, 1'b0);
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    check("rst_rel2", 32'd0, 1'b0);
    @(posedge CLK);
    #1;
    check("post_rst", 32'd300, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter A_width, default 16, bit width of operand A.
REQ-002 Parameter B_width, default 16, bit width of operand B.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 ALU_EN  input  1  operation enable, sampled at rising CLK.
REQ-006 A  input  A_width  operand A, unsigned.
REQ-007 B  input  B_width  operand B, unsigned.
REQ-008 ALU_FUN  input  4  operation select.
REQ-009 ALU_out  output  A_width+B_width (32 at defaults)  registered result.
REQ-010 Out_valid  output  1  registered result-valid flag.

Function
REQ-011 All operands SHALL be treated as unsigned; results zero-extended to output width unless stated.
REQ-012 On a rising CLK with ALU_EN=1, ALU_out SHALL load the result selected by ALU_FUN and Out_valid SHALL be 1; latency is exactly one clock.
REQ-013 On a rising CLK with ALU_EN=0, ALU_out SHALL load 0 and Out_valid SHALL load 0.
REQ-014 ALU_FUN 0: A+B, carry kept in output.
REQ-015 ALU_FUN 1: A-B, modulo 2^(output width) (A<B gives two's-complement wrap).
REQ-016 ALU_FUN 2: A*B, full-width product.
REQ-017 ALU_FUN 3: A/B integer quotient; B=0 SHALL give 0.
REQ-018 ALU_FUN 4..9: bitwise AND, OR, NAND, NOR, XOR, XNOR over max(A_width,B_width) bits of zero-extended operands; bits above that width SHALL be 0.
REQ-019 ALU_FUN 10: 1 if A==B, else 0.
REQ-020 ALU_FUN 11: 2 if A>B, else 0.
REQ-021 ALU_FUN 12: 3 if A<B, else 0.
REQ-022 ALU_FUN 13: A logical shift right by 1 (MSB filled 0).
REQ-023 ALU_FUN 14: A logical shift left by 1, shifted-out bit retained at bit A_width.
REQ-024 ALU_FUN 15: 0; Out_valid still 1 when ALU_EN=1.
REQ-025 Result computation SHALL be combinational from current inputs; only ALU_out and Out_valid are registered.

Reset
REQ-026 Reset=0 SHALL immediately (asynchronously) force ALU_out=0 and Out_valid=0, independent of CLK.
REQ-027 While Reset=0 outputs SHALL hold 0; first update occurs at first rising CLK after Reset returns to 1.
REQ-028 Reset asserted mid-operation SHALL discard the pending result.

Verification
REQ-029 Reset pulse low then high, no CLK edge -> ALU_out=0, Out_valid=0.
REQ-030 EN=1, A=11, B=300, FUN=0 -> after next edge ALU_out=311, Out_valid=1; A=542, B=42, FUN=1 -> 500; A=2222, B=2222, FUN=2 -> 4937284; A=999, B=9, FUN=3 -> 111; B=0, FUN=3 -> 0.
REQ-031 A=16'b1011101010101010, B=16'b1000110011101110: FUN=4 -> 16'b1000100010101010; FUN=6 low 16 bits -> 16'b0111011101010101; FUN=7 -> 16'b0100000100010001; FUN=8 -> 16'b0011011001000100; FUN=9 -> 16'b1100100110111011; upper 16 bits 0 in all.
REQ-032 FUN=10 A=B=762 -> 1, A=342 B=711 -> 0; FUN=11 A=7787 B=778 -> 2, A=7628 B=7911 -> 0; FUN=12 A=7877 B=7977 -> 3, A=7628 B=71 -> 0.
REQ-033 A=16'b1101010110110101: FUN=13 -> 16'b0110101011011010; FUN=14 -> 17'b11010101101101010; FUN=15 -> 0 with Out_valid=1.
REQ-034 EN=0, A=B=6, FUN=0 -> after next edge ALU_out=0, Out_valid=0; EN back to 1 -> 12 one edge later.
